// File: rtl/ch0re_mem_arbiter_if.sv
// Request/response bus between the memory arbiter and the unified memory model.
// One outstanding transaction: req/gnt handshake, then a single rvalid pulse.
interface ch0re_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        be;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ch0re_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU.
// LSU has fixed priority, bounded by a streak limit while fetch is waiting.
module ch0re_mem_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    input  logic              i_lsu_req,
    input  logic              i_lsu_we,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [7:0]        i_lsu_be,
    output logic              o_lsu_gnt,
    output logic              o_lsu_rvalid,
    output logic [DATA_W-1:0] o_lsu_rdata,
    ch0re_mem_arbiter_if.master mem_bus,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);
    localparam logic       OWNER_IF   = 1'b0;
    localparam logic       OWNER_LSU  = 1'b1;

    state_t            r_state;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_be;
    logic              r_sel_hi;
    logic              r_mem_req;
    logic [3:0]        r_streak;
    logic              r_drop;
    logic              r_if_rvalid;
    logic [31:0]       r_if_rdata;
    logic              r_lsu_rvalid;
    logic [DATA_W-1:0] r_lsu_rdata;

    logic w_streak_full;
    logic w_lsu_gnt;
    logic w_if_gnt;
    logic w_if_drop;

    // Same-cycle arbitration in IDLE; grants are suppressed while reset is applied.
    always_comb begin
        w_streak_full = (r_streak == STREAK_MAX);
        w_lsu_gnt     = 1'b0;
        w_if_gnt      = 1'b0;
        w_if_drop     = r_drop || i_if_flush;
        if ((r_state == ST_IDLE) && !rst) begin
            if (i_lsu_req && !(w_streak_full && i_if_req)) begin
                w_lsu_gnt = 1'b1;
            end else if (i_if_req) begin
                w_if_gnt = 1'b1;
            end else begin
                w_lsu_gnt = 1'b0;
                w_if_gnt  = 1'b0;
            end
        end else begin
            w_lsu_gnt = 1'b0;
            w_if_gnt  = 1'b0;
        end
    end

    // Sequencer: latch the winner, drive the memory bus, register the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWNER_IF;
            r_addr       <= {ADDR_W{1'b0}};
            r_we         <= 1'b0;
            r_wdata      <= {DATA_W{1'b0}};
            r_be         <= 8'h00;
            r_sel_hi     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_streak     <= 4'd0;
            r_drop       <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= 32'h0000_0000;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_lsu_gnt) begin
                        r_owner   <= OWNER_LSU;
                        r_addr    <= i_lsu_addr;
                        r_we      <= i_lsu_we;
                        r_wdata   <= i_lsu_wdata;
                        r_be      <= i_lsu_be;
                        r_sel_hi  <= i_lsu_addr[2];
                        r_mem_req <= 1'b1;
                        r_state   <= ST_REQ;
                        // Streak only grows while fetch is actually being starved.
                        if (i_if_req) begin
                            r_streak <= w_streak_full ? r_streak : r_streak + 4'd1;
                        end else begin
                            r_streak <= 4'd0;
                        end
                    end else if (w_if_gnt) begin
                        r_owner   <= OWNER_IF;
                        r_addr    <= i_if_addr;
                        r_we      <= 1'b0;
                        r_wdata   <= {DATA_W{1'b0}};
                        r_be      <= 8'hFF;
                        r_sel_hi  <= i_if_addr[2];
                        r_mem_req <= 1'b1;
                        r_streak  <= 4'd0;
                        r_state   <= ST_REQ;
                    end else begin
                        r_mem_req <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if ((r_owner == OWNER_IF) && i_if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_bus.gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if ((r_owner == OWNER_IF) && i_if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_bus.rvalid) begin
                        r_state <= ST_IDLE;
                        r_drop  <= 1'b0;
                        if (r_owner == OWNER_LSU) begin
                            r_lsu_rvalid <= 1'b1;
                            r_lsu_rdata  <= mem_bus.rdata;
                        end else if (!w_if_drop) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= r_sel_hi ? mem_bus.rdata[63:32] : mem_bus.rdata[31:0];
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_drop    <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_gnt      = w_if_gnt;
    assign o_lsu_gnt     = w_lsu_gnt;
    assign o_if_rvalid   = r_if_rvalid;
    assign o_if_rdata    = r_if_rdata;
    assign o_lsu_rvalid  = r_lsu_rvalid;
    assign o_lsu_rdata   = r_lsu_rdata;
    assign o_busy        = (r_state != ST_IDLE);

    assign mem_bus.req   = r_mem_req;
    assign mem_bus.we    = r_we;
    assign mem_bus.addr  = r_addr;
    assign mem_bus.wdata = r_wdata;
    assign mem_bus.be    = r_be;

endmodule

// File: tb/tb_ch0re_mem_arbiter.sv
// Directed bench for ch0re_mem_arbiter with a delay-programmable memory model.
module tb_ch0re_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req, i_if_flush;
    logic [63:0] i_if_addr;
    logic        o_if_gnt, o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_lsu_req, i_lsu_we;
    logic [63:0] i_lsu_addr, i_lsu_wdata;
    logic [7:0]  i_lsu_be;
    logic        o_lsu_gnt, o_lsu_rvalid;
    logic [63:0] o_lsu_rdata;
    logic        o_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ch0re_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    ch0re_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LSU_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we), .i_lsu_addr(i_lsu_addr),
        .i_lsu_wdata(i_lsu_wdata), .i_lsu_be(i_lsu_be),
        .o_lsu_gnt(o_lsu_gnt), .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
        .mem_bus(bus), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: gnt after gnt_delay waiting cycles, rvalid rv_delay cycles after the first possible slot.
    logic [63:0] mem_arr [0:8191];
    int gnt_delay = 0, rv_delay = 0, gcnt = 0, rcnt = 0;
    logic pend = 1'b0;
    logic [63:0] pend_data = 64'h0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign bus.gnt    = bus.req && (gcnt >= gnt_delay);
    assign bus.rvalid = pend && (rcnt >= rv_delay);
    assign bus.rdata  = pend_data;

    always @(posedge clk) begin
        if (bus.rvalid) pend <= 1'b0;
        else if (pend) rcnt <= rcnt + 1;
        if (bus.req && bus.gnt) begin
            gcnt <= 0;
            pend <= 1'b1;
            rcnt <= 0;
            if (bus.we) begin
                mem_arr[bus.addr[15:3]] <= merge(mem_arr[bus.addr[15:3]], bus.wdata, bus.be);
                pend_data <= 64'h0;
            end else begin
                pend_data <= mem_arr[bus.addr[15:3]];
            end
        end else if (bus.req) begin
            gcnt <= gcnt + 1;
        end else begin
            gcnt <= 0;
        end
    end

    // Monitor: event counts, event cycles, grant order and request-phase bus stability.
    int if_gnt_n = 0, lsu_gnt_n = 0, if_rv_n = 0, lsu_rv_n = 0, mem_rv_n = 0, busy_n = 0, bus_err = 0;
    int if_gnt_cyc = 0, lsu_gnt_cyc = 0, if_rv_cyc = 0, lsu_rv_cyc = 0, mem_rv_cyc = 0, memreq_rise_cyc = 0;
    logic [3:0] streak_at_if = 4'd0;
    bit gnt_seq[$];
    logic prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
    logic [63:0] prev_addr = 64'h0, prev_wdata = 64'h0;
    logic [7:0] prev_be = 8'h0;

    always @(negedge clk) begin
        if (o_if_gnt) begin if_gnt_n++; if_gnt_cyc = cyc; gnt_seq.push_back(1'b0); streak_at_if = dut.r_streak; end
        if (o_lsu_gnt) begin lsu_gnt_n++; lsu_gnt_cyc = cyc; gnt_seq.push_back(1'b1); end
        if (o_if_rvalid) begin if_rv_n++; if_rv_cyc = cyc; end
        if (o_lsu_rvalid) begin lsu_rv_n++; lsu_rv_cyc = cyc; end
        if (bus.rvalid) begin mem_rv_n++; mem_rv_cyc = cyc; end
        if (bus.req && !prev_req) memreq_rise_cyc = cyc;
        if (o_busy) busy_n++;
        if (prev_req && !prev_gnt && !rst) begin
            if (!bus.req || bus.addr != prev_addr || bus.we != prev_we ||
                bus.wdata != prev_wdata || bus.be != prev_be) bus_err++;
        end
        prev_req = bus.req; prev_gnt = bus.gnt; prev_we = bus.we;
        prev_addr = bus.addr; prev_wdata = bus.wdata; prev_be = bus.be;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until both requests are granted and the arbiter is idle again.
    task automatic drain(input bit hold_lsu);
        bit g_if, g_lsu, done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            g_if  = o_if_gnt;
            g_lsu = o_lsu_gnt;
            done  = !i_if_req && !i_lsu_req && !o_busy;
            tick();
            if (g_if) begin
                i_if_req = 1'b0;
                if (hold_lsu) i_lsu_req = 1'b0;
            end
            if (g_lsu && !hold_lsu) i_lsu_req = 1'b0;
        end
        if (!done) check_val("drain_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic wait_gnt(input bit is_lsu);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = is_lsu ? o_lsu_gnt : o_if_gnt;
        end
        if (!seen) check_val("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic lsu_access(input logic we, input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] be);
        i_lsu_req = 1'b1; i_lsu_we = we; i_lsu_addr = addr; i_lsu_wdata = wd; i_lsu_be = be;
        drain(1'b0);
        i_lsu_we = 1'b0;
    endtask

    int n0, b0, e0, m0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_if_req = 1'b0; i_if_flush = 1'b0; i_if_addr = 64'h0;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 64'h2000; i_lsu_wdata = 64'h0; i_lsu_be = 8'hFF;
        repeat (3) tick();
        @(negedge clk);
        check_val("rst_lsu_gnt", {63'd0, o_lsu_gnt}, 64'd0);
        check_val("rst_busy", {63'd0, o_busy}, 64'd0);
        check_val("rst_mem_req", {63'd0, bus.req}, 64'd0);
        check_val("rst_mem_addr", bus.addr, 64'd0);
        check_val("rst_rvalids", {62'd0, o_if_rvalid, o_lsu_rvalid}, 64'd0);
        check_val("rst_rdata", o_lsu_rdata | {32'd0, o_if_rdata}, 64'd0);
        i_lsu_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Preload memory through the arbiter's own store path.
        n0 = lsu_rv_n;
        lsu_access(1'b1, 64'h100,  64'hDEADBEEF_00A00093, 8'hFF);
        lsu_access(1'b1, 64'h2000, 64'hCAFEF00D_12345678, 8'hFF);
        lsu_access(1'b1, 64'h2008, 64'hAABBCCDD_EEFF0011, 8'hFF);
        check_val("store_acks", 64'(lsu_rv_n - n0), 64'd3);

        // Single fetch from the upper word.
        i_if_req = 1'b1; i_if_addr = 64'h104;
        drain(1'b0);
        check_val("fetch_latency", 64'(if_rv_cyc - if_gnt_cyc), 64'd3);
        check_val("fetch_memreq_cyc", 64'(memreq_rise_cyc - if_gnt_cyc), 64'd1);
        check_val("fetch_memrv_cyc", 64'(mem_rv_cyc - if_gnt_cyc), 64'd2);
        check_val("fetch_rdata_hi", {32'd0, o_if_rdata}, 64'h0000_0000_DEADBEEF);

        // Simultaneous fetch and load: LSU first, fetch at the next IDLE cycle.
        gnt_seq.delete();
        i_if_req = 1'b1; i_if_addr = 64'h100;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 64'h2000;
        drain(1'b0);
        check_val("sim_order", {62'd0, gnt_seq[0], gnt_seq[1]}, 64'd2);
        check_val("sim_gnt_gap", 64'(if_gnt_cyc - lsu_gnt_cyc), 64'd3);
        check_val("sim_rv_gap", 64'(if_rv_cyc - lsu_rv_cyc), 64'd3);
        check_val("sim_lsu_rdata", o_lsu_rdata, 64'hCAFEF00D_12345678);
        check_val("sim_if_rdata_lo", {32'd0, o_if_rdata}, 64'h0000_0000_00A00093);
        check_val("sim_streak_clr", {60'd0, dut.r_streak}, 64'd0);

        // Partial store then load back.
        lsu_access(1'b1, 64'h2008, 64'h11223344_55667788, 8'h0F);
        lsu_access(1'b0, 64'h2008, 64'h0, 8'hFF);
        check_val("be_merge", o_lsu_rdata, 64'hAABBCCDD_55667788);

        // Streak limit: LSU held every IDLE cycle against a waiting fetch.
        gnt_seq.delete();
        i_if_req = 1'b1; i_if_addr = 64'h104;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 64'h2000;
        drain(1'b1);
        check_val("streak_len", 64'(gnt_seq.size()), 64'd5);
        check_val("streak_seq", {59'd0, gnt_seq[0], gnt_seq[1], gnt_seq[2], gnt_seq[3], gnt_seq[4]}, 64'h1E);
        check_val("streak_at_fetch", {60'd0, streak_at_if}, 64'd4);
        check_val("streak_after", {60'd0, dut.r_streak}, 64'd0);

        // Slow memory: gnt after 3 wait cycles, rvalid 2 cycles late.
        gnt_delay = 3; rv_delay = 2;
        b0 = busy_n; n0 = lsu_rv_n; e0 = bus_err;
        lsu_access(1'b0, 64'h2008, 64'h0, 8'hFF);
        check_val("slow_latency", 64'(lsu_rv_cyc - lsu_gnt_cyc), 64'd8);
        check_val("slow_busy_cycles", 64'(busy_n - b0), 64'd7);
        check_val("slow_single_rv", 64'(lsu_rv_n - n0), 64'd1);
        check_val("slow_bus_stable", 64'(bus_err - e0), 64'd0);
        check_val("slow_rdata", o_lsu_rdata, 64'hAABBCCDD_55667788);
        gnt_delay = 0; rv_delay = 0;

        // Flush in the memory rvalid cycle drops the fetch response.
        n0 = if_rv_n;
        i_if_req = 1'b1; i_if_addr = 64'h104;
        wait_gnt(1'b0);
        tick(); i_if_req = 1'b0;
        tick(); i_if_flush = 1'b1;
        tick(); i_if_flush = 1'b0;
        repeat (3) tick();
        check_val("flush_memrv_cyc", 64'(mem_rv_cyc - if_gnt_cyc), 64'd2);
        check_val("flush_dropped", 64'(if_rv_n - n0), 64'd0);
        check_val("flush_idle_after", {63'd0, o_busy}, 64'd0);

        // Flush in IDLE alongside a new fetch does not drop it.
        i_if_req = 1'b1; i_if_addr = 64'h100; i_if_flush = 1'b1;
        wait_gnt(1'b0);
        tick(); i_if_req = 1'b0; i_if_flush = 1'b0;
        drain(1'b0);
        check_val("flush_idle_rv", 64'(if_rv_n - n0), 64'd1);
        check_val("flush_idle_rdata", {32'd0, o_if_rdata}, 64'h0000_0000_00A00093);

        // Reset while in RESP; the late memory rvalid must be ignored.
        rv_delay = 5;
        n0 = lsu_rv_n; m0 = mem_rv_n;
        i_lsu_req = 1'b1; i_lsu_we = 1'b0; i_lsu_addr = 64'h2000;
        wait_gnt(1'b1);
        tick(); i_lsu_req = 1'b0;
        tick();
        @(negedge clk);
        check_val("rresp_busy", {62'd0, o_busy, bus.req}, 64'd2);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        repeat (10) tick();
        check_val("rresp_stale_seen", 64'(mem_rv_n - m0), 64'd1);
        check_val("rresp_no_rv", 64'(lsu_rv_n - n0), 64'd0);
        check_val("rresp_rdata", o_lsu_rdata, 64'd0);
        check_val("rresp_idle", {62'd0, o_busy, bus.req}, 64'd0);
        rv_delay = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
